// File: rtl/seq_detect_ctrl.sv
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Serialises framed bytes MSB first and counts overlapping
//            occurrences of a 4-bit pattern, with a threshold interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_detect_ctrl #(
    parameter logic [3:0] PATTERN = 4'b1101,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       din_byte,
    input  logic             din_last,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [CNT_W-1:0] thresh,
    input  logic             irq_clr,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic [2:0]       bidx_q, bidx_d;
    logic [2:0]       hist_q, hist_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic             w_cur_bit;
    logic             w_abort;
    logic             w_start;
    logic             w_hit;
    logic             w_inc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_irq_set;

    assign w_cur_bit = byte_q[bidx_q];
    assign w_abort   = abort && (state_q != S_IDLE);
    assign w_start   = start && (state_q == S_IDLE);
    // An abort in the same cycle as a completing bit suppresses that match.
    assign w_hit     = (state_q == S_SHIFT) && !w_abort && ({hist_q, w_cur_bit} == PATTERN);
    assign w_inc     = w_hit && !(&cnt_q);
    assign w_cnt_inc = cnt_q + CNT_W'(1);
    assign w_irq_set = w_inc && (thresh != '0) && (w_cnt_inc == thresh);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        last_d  = last_q;
        bidx_d  = bidx_q;
        hist_d  = hist_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hist_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (din_valid) begin
                    byte_d  = din_byte;
                    last_d  = din_last;
                    bidx_d  = 3'd7;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                hist_d = {hist_q[1:0], w_cur_bit};
                if (bidx_q == 3'd0) begin
                    state_d = last_q ? S_DONE : S_LOAD;
                end else begin
                    bidx_d = bidx_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (w_abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        pulse_d = w_hit;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        if (w_start) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else begin
            if (w_inc) begin
                cnt_d = w_cnt_inc;
            end
            // A coincident set wins over a clear request.
            if (w_irq_set) begin
                irq_d = 1'b1;
            end else if (irq_clr) begin
                irq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            last_q  <= 1'b0;
            bidx_q  <= '0;
            hist_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            bidx_q  <= bidx_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    assign din_ready   = (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign match_pulse = pulse_q;
    assign match_count = cnt_q;
    assign irq         = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Self-checking bench for seq_detect_ctrl (8-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_detect_ctrl;

    localparam logic [3:0] PAT = 4'b1101;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic [7:0] din_byte  = 8'h00;
    logic       din_last  = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] thresh    = 8'h00;
    logic [1:0] thresh2   = 2'd0;
    logic       irq_clr   = 1'b0;

    logic       din_ready, match_pulse, irq, busy, done;
    logic [7:0] match_count;
    logic       din_ready_2, match_pulse_2, irq_2, busy_2, done_2;
    logic [1:0] match_count_2;

    seq_detect_ctrl #(.PATTERN(PAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .din_byte(din_byte), .din_last(din_last), .din_valid(din_valid),
        .din_ready(din_ready), .thresh(thresh), .irq_clr(irq_clr),
        .match_pulse(match_pulse), .match_count(match_count), .irq(irq),
        .busy(busy), .done(done)
    );

    seq_detect_ctrl #(.PATTERN(PAT), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .din_byte(din_byte), .din_last(din_last), .din_valid(din_valid),
        .din_ready(din_ready_2), .thresh(thresh2), .irq_clr(irq_clr),
        .match_pulse(match_pulse_2), .match_count(match_count_2), .irq(irq_2),
        .busy(busy_2), .done(done_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   c8;
        int   c2;
        logic irq;
    } exp_t;

    exp_t       q[$];
    logic [7:0] fb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] m_hist;
    int         m_c8, m_c2;
    logic       m_irq;
    logic       m_clr_held = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_start();
        m_hist = 3'b000;
        m_c8   = 0;
        m_c2   = 0;
        m_irq  = 1'b0;
    endfunction

    function automatic int model_byte(input logic [7:0] b);
        int   n = 0;
        logic bit_v;
        logic set_v;
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            bit_v = b[i];
            if ({m_hist, bit_v} == PAT) begin
                n++;
                set_v = 1'b0;
                if (m_c8 < 255) begin
                    m_c8++;
                    set_v = (thresh != 8'h00) && (m_c8 == int'(thresh));
                end
                if (set_v) m_irq = 1'b1;
                else if (m_clr_held) m_irq = 1'b0;
                if (m_c2 < 3) m_c2++;
                e.c8  = m_c8;
                e.c2  = m_c2;
                e.irq = m_irq;
                q.push_back(e);
            end
            m_hist = {m_hist[1:0], bit_v};
        end
        return n;
    endfunction

    // Runs one frame of the bytes in fb; start optionally held through the frame.
    task automatic run_frame(input bit hold_start, output int npulse);
        exp_t e;
        int   w;
        npulse = 0;
        q.delete();
        model_start();
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < fb.size(); k++) begin
            w = 0;
            while (!din_ready && w < 4) begin
                step();
                w++;
            end
            n_cmp++;
            if (din_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL din_ready_wait byte %0d: din_ready=%b required 1", k, din_ready);
            end
            din_byte  = fb[k];
            din_last  = (k == fb.size() - 1);
            din_valid = 1'b1;
            void'(model_byte(fb[k]));
            step();
            din_valid = 1'b0;
            din_last  = 1'b0;
            if (k == fb.size() - 1) start = 1'b0;
            for (int s = 0; s < 8; s++) begin
                step();
                if (match_pulse) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_pulse byte %0d bit %0d: pulse=1 required 0", k, 7 - s);
                    end else begin
                        e = q.pop_front();
                        npulse++;
                        if (match_count !== 8'(e.c8) || match_count_2 !== 2'(e.c2) || irq !== e.irq) begin
                            n_bad++;
                            $display("FAIL pulse_state: count=%0d/%0d irq=%b required %0d/%0d irq=%b",
                                     match_count, match_count_2, irq, e.c8, e.c2, e.irq);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL done_pulse: done=%b busy=%b required 1 1", done, busy);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_idle: done=%b busy=%b required 0 0", done, busy);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missed_pulses: outstanding=%0d required 0", q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_cmp++;
        if ({busy, din_ready, done, match_pulse, irq} !== 5'b0 || match_count !== 8'h00 || match_count_2 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy/rdy/done/pulse/irq=%b count=%0d required 00000 0",
                     {busy, din_ready, done, match_pulse, irq}, match_count);
        end
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0 || din_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b required 0 0", busy, din_ready);
        end
    endtask

    task automatic test_dual_match();
        int n;
        thresh = 8'd0;
        fb = '{8'hDB};
        run_frame(1'b0, n);
        n_cmp++;
        if (n != 2 || match_count !== 8'd2 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL dual_match: pulses=%0d count=%0d irq=%b required 2 2 0", n, match_count, irq);
        end
    endtask

    task automatic test_boundary();
        int n;
        fb = '{8'h01, 8'hA0};
        run_frame(1'b0, n);
        n_cmp++;
        if (n != 1 || match_count !== 8'd1) begin
            n_bad++;
            $display("FAIL boundary_match: pulses=%0d count=%0d required 1 1", n, match_count);
        end
    endtask

    task automatic test_no_match();
        int n;
        fb = '{8'hFF};
        run_frame(1'b0, n);
        n_cmp++;
        if (n != 0 || match_count !== 8'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL no_match: pulses=%0d count=%0d irq=%b required 0 0 0", n, match_count, irq);
        end
    endtask

    task automatic test_irq();
        int n;
        thresh = 8'd2;
        fb = '{8'hDB};
        run_frame(1'b0, n);
        step();
        step();
        n_cmp++;
        if (irq !== 1'b1 || match_count !== 8'd2) begin
            n_bad++;
            $display("FAIL irq_hold_idle: irq=%b count=%0d required 1 2", irq, match_count);
        end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        n_cmp++;
        if (irq !== 1'b0 || match_count !== 8'd2) begin
            n_bad++;
            $display("FAIL irq_clear: irq=%b count=%0d required 0 2", irq, match_count);
        end
        // Clear held through the whole frame: the set at the first match must win.
        thresh     = 8'd1;
        m_clr_held = 1'b1;
        irq_clr    = 1'b1;
        run_frame(1'b0, n);
        irq_clr    = 1'b0;
        m_clr_held = 1'b0;
        n_cmp++;
        if (n != 2 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_clr_held: pulses=%0d irq=%b required 2 0", n, irq);
        end
        thresh = 8'd0;
    endtask

    task automatic test_back_to_back_saturate();
        int n;
        fb = '{8'hDB, 8'hDB, 8'hDB, 8'hDB};
        run_frame(1'b1, n);
        n_cmp++;
        if (n != 8 || match_count !== 8'd8 || match_count_2 !== 2'd3) begin
            n_bad++;
            $display("FAIL saturate: pulses=%0d count=%0d count2=%0d required 8 8 3",
                     n, match_count, match_count_2);
        end
    endtask

    task automatic test_abort();
        int bad_cycles = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        din_byte  = 8'hDB;
        din_last  = 1'b1;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din_last  = 1'b0;
        for (int s = 0; s < 6; s++) step();
        n_cmp++;
        if (match_count !== 8'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_setup: count=%0d busy=%b required 1 1", match_count, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || din_ready !== 1'b0 || match_pulse !== 1'b0 || match_count !== 8'd1) begin
            n_bad++;
            $display("FAIL abort_idle: busy=%b rdy=%b pulse=%b count=%0d required 0 0 0 1",
                     busy, din_ready, match_pulse, match_count);
        end
        for (int s = 0; s < 10; s++) begin
            step();
            if (done || match_pulse || busy) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0 || match_count !== 8'd1) begin
            n_bad++;
            $display("FAIL abort_quiet: bad_cycles=%0d count=%0d required 0 1", bad_cycles, match_count);
        end
    endtask

    task automatic test_reset_mid_shift();
        thresh = 8'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        din_byte  = 8'hDB;
        din_last  = 1'b1;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din_last  = 1'b0;
        for (int s = 0; s < 4; s++) step();
        n_cmp++;
        if (match_pulse !== 1'b1 || irq !== 1'b1 || match_count !== 8'd1) begin
            n_bad++;
            $display("FAIL reset_setup: pulse=%b irq=%b count=%0d required 1 1 1", match_pulse, irq, match_count);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, din_ready, done, match_pulse, irq} !== 5'b0 || match_count !== 8'h00 || match_count_2 !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy/rdy/done/pulse/irq=%b count=%0d required 00000 0",
                     {busy, din_ready, done, match_pulse, irq}, match_count);
        end
        #2 reset = 1'b1;
        for (int s = 0; s < 12; s++) step();
        n_cmp++;
        if (busy !== 1'b0 || din_ready !== 1'b0 || match_pulse !== 1'b0 || match_count !== 8'd0) begin
            n_bad++;
            $display("FAIL stay_idle: busy=%b rdy=%b pulse=%b count=%0d required 0 0 0 0",
                     busy, din_ready, match_pulse, match_count);
        end
        thresh = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dual_match();
        test_boundary();
        test_no_match();
        test_irq();
        test_back_to_back_saturate();
        test_abort();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1101, meaning the 4-bit serial pattern to detect (first-received bit is PATTERN[3]).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the match counter and threshold.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  begin a frame; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the frame; honoured in any non-IDLE state.
REQ-007 SHALL have port din_byte  input  8  parallel data byte, shifted out MSB first.
REQ-008 SHALL have port din_last  input  1  qualifies din_byte as the final byte of the frame.
REQ-009 SHALL have port din_valid  input  1  din_byte/din_last valid.
REQ-010 SHALL have port din_ready  output  1  block accepts a byte this cycle.
REQ-011 SHALL have port thresh  input  CNT_W  match count that raises irq; 0 disables irq.
REQ-012 SHALL have port irq_clr  input  1  clears irq.
REQ-013 SHALL have port match_pulse  output  1  one-cycle pulse per detected pattern.
REQ-014 SHALL have port match_count  output  CNT_W  matches in the current/last frame.
REQ-015 SHALL have port irq  output  1  sticky threshold interrupt.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at normal frame completion.

Function
REQ-018 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-019 In IDLE, start=1 SHALL clear match_count, irq and the 3-bit bit-history register, and SHALL move to LOAD; start in any other state SHALL be ignored.
REQ-020 In LOAD, din_ready SHALL be 1 (combinational on state); it SHALL be 0 in all other states.
REQ-021 A byte SHALL be accepted on din_valid&din_ready; byte and din_last are captured and the state moves to SHIFT with bit index 7.
REQ-022 In SHIFT, exactly one bit per cycle SHALL be consumed, b7 first through b0 (8 cycles); a byte costs 9 cycles including the LOAD handshake.
REQ-023 After b0, the state SHALL move to DONE if the captured last flag is 1, else to LOAD.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 Match SHALL be detected when {history[2:0], current bit} == PATTERN; history then shifts in the current bit (overlapping detection).
REQ-026 History SHALL persist across byte boundaries within a frame and SHALL be cleared only by reset or start.
REQ-027 match_pulse SHALL be registered: high for the one cycle after the cycle that consumed the completing bit.
REQ-028 match_count SHALL increment in the same cycle match_pulse rises and SHALL saturate at all-ones.
REQ-029 irq SHALL set when match_count transitions to a value equal to a nonzero thresh; it SHALL stay set until irq_clr, start or reset.
REQ-030 Simultaneous irq set and irq_clr SHALL leave irq set.
REQ-031 abort SHALL force IDLE on the next edge from any state, with no done pulse and no further matches; match_count and irq SHALL be retained; abort has priority over all other transitions.
REQ-032 match_count and irq SHALL hold their values in IDLE until the next start.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE and set history, bit index, match_count, match_pulse, irq and done to 0; busy and din_ready SHALL read 0.
REQ-034 Reset asserted mid-SHIFT SHALL discard the byte in flight; after release the block SHALL stay in IDLE until start.

Verification
REQ-035 start; byte 0xDB with last -> exactly 2 match_pulses; match_count=2; done one cycle after the b0 SHIFT cycle; busy falls with return to IDLE.
REQ-036 start; bytes 0x01 then 0xA0 (last) -> exactly 1 match spanning the byte boundary; match_count=1.
REQ-037 start; byte 0xFF, last -> 0 matches; done=1; irq=0.
REQ-038 thresh=2; 0xDB frame -> irq rises with the second match_pulse; irq_clr asserted alongside a later set stays 1; irq_clr alone -> 0.
REQ-039 CNT_W=2; four 0xDB bytes -> match_count saturates at 3, no wrap.
REQ-040 abort in SHIFT -> IDLE next cycle, no done, count kept; separately reset low mid-SHIFT -> all outputs 0 immediately.
